score_bcd_formatter: RTL
========================

// Module: score_bcd_formatter
// PURPOSE
//  Downstream of the game block. Converts the signed 11-bit game score into four
//  7-bit digit codes that drive the clock_display digit_0..digit_3 inputs.
//  Uses a sequential double-dabble conversion, one shift per clock.
//  Has a start/busy/done handshake; the state manager muxes the outputs onto the display.
// PARAMETERS
//  W_PTS       11        score width; two's complement
//  CODE_MINUS  7'd18     digit code shown for a negative sign
//  CODE_BLANK  7'd31     digit code for an unlit digit
// PORTS
//  clk        in   1   system clock; all state changes on posedge
//  rst_n      in   1   asynchronous, active-low reset
//  start      in   1   conversion request, sampled on posedge
//  points     in   11  signed score, captured when start is accepted
//  busy       out  1   high while a conversion is in progress
//  done       out  1   one-cycle pulse when new digits are valid
//  negative   out  1   sign of the last completed conversion
//  digit_0    out  7   ones digit code (0-9)
//  digit_1    out  7   tens digit code
//  digit_2    out  7   hundreds digit code
//  digit_3    out  7   thousands digit code, or CODE_MINUS
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; busy=0, done=0, negative=0
//   - digit_0..3=7'd0; shift/BCD registers cleared
//  States: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
//  IDLE:
//   - start=1 captures points, sets busy=1, goes to LOAD
//  LOAD (1 cycle):
//   - mag = points[10] ? -points : points, computed in 12 bits so -1024 -> 1024
//   - sign latched internally; BCD accumulator = 0; shift counter = W_PTS
//  SHIFT (W_PTS cycles):
//   - add 3 to each BCD nibble >= 5, then shift {bcd,mag} left by 1
//   - counter decrements; leaves SHIFT when counter reaches 0
//  DONE (1 cycle):
//   - registers digit_0..3 and negative; done=1; busy=0 on the next edge
//  Latency: start sampled at edge N -> done high for the cycle after edge N+W_PTS+2.
//   That is 13 cycles for W_PTS=11.
//  Output format:
//   - Non-negative: digit_3..0 = thousands..ones (0..1023).
//   - Negative: digit_3 = CODE_MINUS; digits 2..0 = magnitude saturated to 999.
//     -1024 displays as "-999".
//  Outputs hold their last completed value until the next DONE; never partially updated.
//  start while busy=1 is ignored; no queueing. start in DONE is also ignored.
//  start held high continuously re-triggers each time IDLE is re-entered.
//  points changing after capture has no effect on the conversion in flight.
//  Reset mid-conversion: aborts immediately; outputs return to reset values; no done pulse.
// CONFIGURATION
//  LEADING_BLANK_EN defined:
//   - leading zero digits above the most significant non-zero digit output CODE_BLANK.
//   - digit_0 is never blanked.
//   - Negative: CODE_MINUS stays in digit_3; zeros in digits 2..1 are blanked.
//     e.g. -7 -> "-", blank, blank, 7.
//  LEADING_BLANK_EN undefined: all digits show numeric codes, zero-padded ("0042").
//  Blanking is applied in the DONE cycle only; latency is unchanged in both builds.
// TESTING
//  1. Reset, then start with points=42 -> done at cycle 13; digits 3..0 = 0,0,4,2; negative=0.
//  2. points=1023 -> 1,0,2,3; points=0 -> 0,0,0,0 (LEADING_BLANK_EN: BLANK,BLANK,BLANK,0).
//  3. points=-5 (11'h7FB) -> MINUS,0,0,5; negative=1.
//     points=-1024 -> MINUS,9,9,9.
//  4. start at cycle 0 with points=100, second start at cycle 5 with points=7
//     -> one done only; digits show 100; busy low afterwards.
//  5. rst_n=0 at cycle 6 of a conversion -> busy=0 immediately; digits=0; no done;
//     a new start converts correctly.
//  6. Back-to-back: start held high, points 12 then 34 -> two done pulses 14 cycles apart,
//     with correct digits each time.

Source files
------------

// File: rtl/score_bcd_formatter.sv
// Signed score to four display digit codes via sequential double-dabble (one shift per clk).
// Latency: start sampled at edge N -> done for the cycle after edge N+W_PTS+2; start ignored while busy.
// Build option: define LEADING_BLANK_EN to blank leading zero digits with CODE_BLANK.
module score_bcd_formatter #(
    parameter int         W_PTS      = 11,
    parameter logic [6:0] CODE_MINUS = 7'd18,
    parameter logic [6:0] CODE_BLANK = 7'd31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W_PTS-1:0] points,
    output logic             busy,
    output logic             done,
    output logic             negative,
    output logic [6:0]       digit_0,
    output logic [6:0]       digit_1,
    output logic [6:0]       digit_2,
    output logic [6:0]       digit_3
);

    localparam int CNT_W = $clog2(W_PTS + 1);

`ifdef LEADING_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_nx;
    logic [W_PTS-1:0]   pts_q;
    logic [W_PTS-1:0]   mag_q;
    logic               sign_q;
    logic [15:0]        bcd_q;
    logic [15:0]        bcd_adj;
    logic [CNT_W-1:0]   cnt_q;
    logic [6:0]         fmt_0;
    logic [6:0]         fmt_1;
    logic [6:0]         fmt_2;
    logic [6:0]         fmt_3;
    logic               blank_1;
    logic               blank_2;
    logic               blank_3;

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Double-dabble datapath
    // ---------------------------------------------------------------
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Magnitude is kept unsigned in W_PTS bits: negating the most negative
    // score wraps to exactly 2^(W_PTS-1), which is the correct magnitude.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pts_q  <= '0;
            mag_q  <= '0;
            sign_q <= 1'b0;
            bcd_q  <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) pts_q <= points;
                end
                LOAD: begin
                    sign_q <= pts_q[W_PTS-1];
                    mag_q  <= pts_q[W_PTS-1] ? -pts_q : pts_q;
                    bcd_q  <= '0;
                    cnt_q  <= CNT_W'(W_PTS);
                end
                SHIFT: begin
                    {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
                    cnt_q          <= cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Output formatting (sign, saturation, optional blanking)
    // ---------------------------------------------------------------
    always_comb begin
        fmt_0 = {3'b000, bcd_q[3:0]};
        fmt_1 = {3'b000, bcd_q[7:4]};
        fmt_2 = {3'b000, bcd_q[11:8]};
        fmt_3 = {3'b000, bcd_q[15:12]};
        if (sign_q) begin
            fmt_3 = CODE_MINUS;
            // Negative magnitudes above 999 have no room beside the sign.
            if (bcd_q[15:12] != 4'd0) begin
                fmt_0 = 7'd9;
                fmt_1 = 7'd9;
                fmt_2 = 7'd9;
            end
        end
        blank_3 = BLANK_EN && !sign_q && (fmt_3 == 7'd0);
        blank_2 = BLANK_EN && (sign_q || blank_3) && (fmt_2 == 7'd0);
        blank_1 = blank_2 && (fmt_1 == 7'd0);
        if (blank_3) fmt_3 = CODE_BLANK;
        if (blank_2) fmt_2 = CODE_BLANK;
        if (blank_1) fmt_1 = CODE_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            negative <= 1'b0;
            digit_0  <= 7'd0;
            digit_1  <= 7'd0;
            digit_2  <= 7'd0;
            digit_3  <= 7'd0;
        end else begin
            busy <= (state_nx != IDLE);
            done <= (state_q == DONE);
            if (state_q == DONE) begin
                negative <= sign_q;
                digit_0  <= fmt_0;
                digit_1  <= fmt_1;
                digit_2  <= fmt_2;
                digit_3  <= fmt_3;
            end
        end
    end

endmodule
